// File: rtl/pattern_buffer_bank.sv
// Bank of NBUF pattern buffers loaded over an oversampled serial port through a
// shadow register with all-or-nothing commit; drives the selected buffer/field out.
module pattern_buffer_bank #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32,
  parameter int NBUF  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sclk,
  input  logic                       sin,
  input  logic                       ssel,
  input  logic [$clog2(NBUF)-1:0]    saddr,
  output logic                       sout,
  input  logic                       incbufp,
  input  logic                       incfieldp,
  input  logic                       autofield,
  output logic [$clog2(NBUF)-1:0]    bufp,
  output logic [$clog2(DEPTH)-1:0]   fieldp,
  output logic [WIDTH*DEPTH-1:0]     pattern_out,
  output logic [WIDTH-1:0]           field_byte_out,
  output logic                       load_done,
  output logic                       load_err
);
  localparam int N  = WIDTH * DEPTH;
  localparam int BW = $clog2(NBUF);
  localparam int FW = $clog2(DEPTH);
  localparam int CW = $clog2(N + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(N);
  localparam logic [CW-1:0] CNT_SAT  = CW'(N + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  // [0],[1] form the synchroniser; [2] is the delayed copy used for edge detection
  logic [2:0] sclk_q, ssel_q;
  logic [1:0] sin_q;

  logic [1:0]            state_q, state_d;
  logic [BW-1:0]         ladr_q, ladr_d;
  logic [N-1:0]          shadow_q, shadow_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NBUF-1:0][N-1:0] bufs_q;
  logic [BW-1:0]         bufp_q, bufp_d;
  logic [FW-1:0]         fieldp_q, fieldp_d;
  logic [N-1:0]          pattern_q;
  logic [WIDTH-1:0]      field_q;
  logic                  sout_q, load_done_q, load_err_q;
  logic                  commit_ok, commit_bad;
  logic                  sclk_rise, ssel_rise, ssel_fall;
  logic                  fadv, fwrap;

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign ssel_rise = ssel_q[1] & ~ssel_q[2];
  assign ssel_fall = ~ssel_q[1] & ssel_q[2];

  always_comb begin
    state_d    = state_q;
    ladr_d     = ladr_q;
    shadow_d   = shadow_q;
    cnt_d      = cnt_q;
    commit_ok  = 1'b0;
    commit_bad = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ssel_rise) begin
          ladr_d   = saddr;
          shadow_d = bufs_q[saddr];
          cnt_d    = '0;
          state_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // frame end wins over a coincident sclk rise
        if (ssel_fall) begin
          state_d = S_COMMIT;
        end else if (sclk_rise) begin
          shadow_d = {shadow_q[N-2:0], sin_q[1]};
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + CW'(1);
        end
      end
      S_COMMIT: begin
        commit_ok  = (cnt_q == CNT_FULL);
        commit_bad = (cnt_q != CNT_FULL);
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // auto mode chains into the next buffer when the field pointer wraps
  always_comb begin
    fadv     = incfieldp | autofield;
    fwrap    = fadv & (fieldp_q == '1);
    fieldp_d = fieldp_q + FW'(fadv);
    bufp_d   = bufp_q + BW'(incbufp | (autofield & fwrap));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_q      <= '0;
      ssel_q      <= '0;
      sin_q       <= '0;
      state_q     <= S_IDLE;
      ladr_q      <= '0;
      shadow_q    <= '0;
      cnt_q       <= '0;
      bufs_q      <= '0;
      bufp_q      <= '0;
      fieldp_q    <= '0;
      pattern_q   <= '0;
      field_q     <= '0;
      sout_q      <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      sclk_q      <= {sclk_q[1:0], sclk};
      ssel_q      <= {ssel_q[1:0], ssel};
      sin_q       <= {sin_q[0], sin};
      state_q     <= state_d;
      ladr_q      <= ladr_d;
      shadow_q    <= shadow_d;
      cnt_q       <= cnt_d;
      if (commit_ok) bufs_q[ladr_q] <= shadow_q;
      bufp_q      <= bufp_d;
      fieldp_q    <= fieldp_d;
      pattern_q   <= bufs_q[bufp_q];
      field_q     <= bufs_q[bufp_q][fieldp_q*WIDTH +: WIDTH];
      sout_q      <= (state_q != S_IDLE) ? shadow_q[N-1] : 1'b0;
      load_done_q <= commit_ok;
      load_err_q  <= commit_bad;
    end
  end

  assign sout           = sout_q;
  assign bufp           = bufp_q;
  assign fieldp         = fieldp_q;
  assign pattern_out    = pattern_q;
  assign field_byte_out = field_q;
  assign load_done      = load_done_q;
  assign load_err       = load_err_q;
endmodule

// File: tb/tb_pattern_buffer_bank.sv
// Directed bench for pattern_buffer_bank: buffer/pointer model plus per-cycle compare.
module tb_pattern_buffer_bank;
  localparam int WIDTH = 8, DEPTH = 32, NBUF = 8;
  localparam int N = WIDTH * DEPTH, BW = 3, FW = 5;

  logic clk = 0, reset = 1, sclk = 0, sin = 0, ssel = 0;
  logic incbufp = 0, incfieldp = 0, autofield = 0;
  logic [BW-1:0] saddr = '0, bufp;
  logic [FW-1:0] fieldp;
  logic sout, load_done, load_err;
  logic [N-1:0] pattern_out;
  logic [WIDTH-1:0] field_byte_out;

  int errors = 0, checks = 0;
  bit busy = 1, cmp_en = 0;

  logic [N-1:0] mbuf [NBUF];
  int mb = 0, mf = 0;
  logic [N-1:0] exp_pat = '0;
  logic [WIDTH-1:0] exp_fld = '0;
  logic [N-1:0] pat_a5, ramp, top_bit;

  always #5 clk = ~clk;

  pattern_buffer_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NBUF(NBUF)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .sin(sin), .ssel(ssel), .saddr(saddr),
    .sout(sout), .incbufp(incbufp), .incfieldp(incfieldp), .autofield(autofield),
    .bufp(bufp), .fieldp(fieldp), .pattern_out(pattern_out),
    .field_byte_out(field_byte_out), .load_done(load_done), .load_err(load_err)
  );

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 20) $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: outputs show the buffer addressed by last cycle's pointers.
  always @(posedge clk) begin
    if (reset) begin
      mb = 0; mf = 0; exp_pat = '0; exp_fld = '0;
      for (int i = 0; i < NBUF; i++) mbuf[i] = '0;
    end else begin
      int adv;
      bit wrap;
      exp_pat = mbuf[mb];
      exp_fld = mbuf[mb][mf*WIDTH +: WIDTH];
      adv  = (incfieldp || autofield) ? 1 : 0;
      wrap = (adv == 1) && (mf == DEPTH - 1);
      mf   = (mf + adv) % DEPTH;
      if (incbufp || (autofield && wrap)) mb = (mb + 1) % NBUF;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("bufp", N'(bufp), N'(mb));
      check("fieldp", N'(fieldp), N'(mf));
      if (!busy) begin
        check("pattern_out", pattern_out, exp_pat);
        check("field_byte_out", N'(field_byte_out), N'(exp_fld));
        check("sout_idle", N'(sout), '0);
        check("load_done_idle", N'(load_done), '0);
        check("load_err_idle", N'(load_err), '0);
      end
    end
  end

  task automatic send_bit(input logic b);
    sin = b; sclk = 0;
    repeat (4) @(negedge clk);
    sclk = 1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_frame(input int addr, input int nbits, input logic [N-1:0] pat);
    logic [N-1:0] old;
    int nd, ne;
    busy = 1; saddr = BW'(addr); old = mbuf[addr];
    @(negedge clk); ssel = 1;
    repeat (6) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      sin = (i < N) ? pat[N-1-i] : 1'b1; sclk = 0;
      repeat (4) @(negedge clk);
      if (i < N) check("sout_readback", N'(sout), N'(old[N-1-i]));
      sclk = 1;
      repeat (4) @(negedge clk);
    end
    sclk = 0;
    repeat (4) @(negedge clk);
    ssel = 0; nd = 0; ne = 0;
    repeat (12) begin
      @(negedge clk);
      nd += int'(load_done); ne += int'(load_err);
    end
    check("load_done_pulses", N'(nd), N'(nbits == N));
    check("load_err_pulses", N'(ne), N'(nbits != N));
    if (nbits == N) mbuf[addr] = pat;
    repeat (3) @(negedge clk);
    busy = 0;
  endtask

  task automatic step(input bit b, input bit f, input int n);
    incbufp = b; incfieldp = f;
    repeat (n) @(negedge clk);
    incbufp = 0; incfieldp = 0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd, ne;
    pat_a5 = {32{8'hA5}};
    top_bit = '0; top_bit[N-1] = 1'b1;
    for (int f = 0; f < DEPTH; f++) ramp[f*WIDTH +: WIDTH] = 8'(f * 3 + 1);
    for (int i = 0; i < NBUF; i++) mbuf[i] = '0;

    repeat (3) @(negedge clk);
    cmp_en = 1;
    check("rst_bufp", N'(bufp), '0);
    check("rst_fieldp", N'(fieldp), '0);
    check("rst_pattern", pattern_out, '0);
    check("rst_sout", N'(sout), '0);
    check("rst_done_err", N'({load_done, load_err}), '0);
    reset = 0; busy = 0;
    repeat (3) @(negedge clk);

    // full 0xA5 frame into buffer 2, then select it
    send_frame(2, N, pat_a5);
    step(1, 0, 2);
    repeat (2) @(negedge clk);
    check("a5_bufp", N'(bufp), N'(2));
    check("a5_pattern", pattern_out, {32{8'hA5}});
    check("a5_field", N'(field_byte_out), N'(8'hA5));

    // short and long frames are rejected
    send_frame(2, N - 1, '0);
    check("short_keeps", pattern_out, {32{8'hA5}});
    send_frame(2, N + 1, '0);
    check("long_keeps", pattern_out, {32{8'hA5}});

    // buffer 1: field31=0x80, then read it back while loading a ramp
    send_frame(1, N, top_bit);
    send_frame(1, N, ramp);
    step(1, 0, 7);
    step(0, 1, 5);
    repeat (2) @(negedge clk);
    check("ramp_ptrs", N'({bufp, fieldp}), N'({3'd1, 5'd5}));
    check("ramp_field5", N'(field_byte_out), N'(8'd16));
    check("ramp_pattern", pattern_out, ramp);

    // autofield chaining from bufp=7, fieldp=0
    step(0, 1, 27);
    step(1, 0, 6);
    check("auto_start", N'({bufp, fieldp}), N'({3'd7, 5'd0}));
    autofield = 1;
    repeat (31) @(negedge clk);
    check("auto_f31", N'({bufp, fieldp}), N'({3'd7, 5'd31}));
    incbufp = 1;
    @(negedge clk);
    incbufp = 0; autofield = 0;
    check("auto_wrap", N'({bufp, fieldp}), N'({3'd0, 5'd0}));
    repeat (3) @(negedge clk);

    // reset in the middle of a frame
    busy = 1; saddr = 3;
    @(negedge clk); ssel = 1;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 100; i++) send_bit(1'b1);
    reset = 1; ssel = 0; sclk = 0; sin = 0; nd = 0; ne = 0;
    repeat (3) begin
      @(negedge clk);
      nd += int'(load_done); ne += int'(load_err);
    end
    check("midrst_sout", N'(sout), '0);
    check("midrst_pattern", pattern_out, '0);
    reset = 0;
    repeat (12) begin
      @(negedge clk);
      nd += int'(load_done); ne += int'(load_err);
    end
    check("midrst_pulses", N'({nd[7:0], ne[7:0]}), '0);
    busy = 0;
    step(1, 0, 2);
    repeat (2) @(negedge clk);
    check("midrst_buf2_clear", pattern_out, '0);
    send_frame(3, N, ramp);
    step(1, 0, 1);
    repeat (2) @(negedge clk);
    check("post_rst_commit", pattern_out, ramp);
    check("post_rst_field0", N'(field_byte_out), N'(8'd1));

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pattern_buffer_bank.md
Name: pattern_buffer_bank

Overview:
- Parametrised, single-clock successor to the 8-bit pattern buffer.
- Holds NBUF pattern buffers of DEPTH fields, each WIDTH bits wide.
- Loads one buffer at a time over an oversampled serial port (sclk/sin/ssel/saddr), with shadow-register staging and all-or-nothing commit.
- Drives the selected buffer and field to the pattern processor core.
- Adds what the previous generation lacked:
  - reset;
  - serial readback on sout;
  - length checking;
  - auto-advancing field pointer with buffer chaining.

Parameters:
- WIDTH, 8, bits per field.
- DEPTH, 32, fields per buffer; power of two, >= 2.
- NBUF, 8, number of buffers; power of two, >= 2.
- Derived constants:
  - N = WIDTH*DEPTH;
  - BW = clog2(NBUF);
  - FW = clog2(DEPTH).

Ports:
- clk  in  1  system clock; every flop uses its rising edge.
- reset  in  1  synchronous, active-high reset.
- sclk  in  1  serial clock, sampled by clk. High and low phases each last >= 3 clk periods.
- sin  in  1  serial data. Stable around the sclk rising edge.
- ssel  in  1  serial frame select, active high.
- saddr  in  BW  target buffer. Sampled at the ssel rise.
- sout  out  1  serial readback data.
- incbufp  in  1  advance buffer pointer.
- incfieldp  in  1  advance field pointer.
- autofield  in  1  mode: field pointer advances every clk.
- bufp  out  BW  current buffer pointer.
- fieldp  out  FW  current field pointer.
- pattern_out  out  N  registered copy of buffer[bufp]. Field f occupies bits [f*WIDTH +: WIDTH].
- field_byte_out  out  WIDTH  registered buffer[bufp] field fieldp.
- load_done  out  1  one-clk pulse on successful commit.
- load_err  out  1  one-clk pulse on rejected frame.

Behaviour:
- Reset (synchronous, active high):
  - all buffers, shadow register, pointers, bit count and all outputs go to 0;
  - state goes to IDLE.
  - Reset during SHIFT aborts the frame: no commit and no load_err.
- Input synchronisation:
  - sclk, sin and ssel each pass through a 2-flop synchroniser.
  - Edge detection compares the 2nd synchroniser stage with a 3rd, delayed stage.
  - A pin event is therefore acted on at the 3rd clk edge after it occurs.
  - sin is taken from the same synchroniser stage as sclk.
- FSM, IDLE:
  - On a ssel rise: latch saddr into ladr, load shadow <= buffer[saddr], clear count, go to SHIFT.
- FSM, SHIFT:
  - Each sclk rise: shadow <= {shadow[N-2:0], sin}.
  - Each sclk rise: count <= count+1, saturating at N+1.
  - On a ssel fall: go to COMMIT.
  - An sclk rise in the same clk as the ssel fall is ignored.
- FSM, COMMIT (lasts 1 clk):
  - If count == N: buffer[ladr] <= shadow and pulse load_done.
  - Otherwise: buffer unchanged and pulse load_err. This covers count < N and count > N.
  - Then return to IDLE.
- Serial ordering and readback:
  - The first bit received ends up in bit N-1, i.e. the MSB of field DEPTH-1.
  - sout = shadow[N-1], registered.
  - While shifting, sout streams out the old contents of buffer[ladr], MSB-first.
  - sout is 0 in IDLE.
- Pointers:
  - fieldp advances by 1 when incfieldp or autofield is high; never by 2.
  - fieldp wraps from DEPTH-1 to 0.
  - bufp advances by 1 when incbufp is high, or when autofield is high and fieldp wraps that cycle.
  - If both bufp conditions hold, bufp still advances by exactly 1.
  - bufp wraps from NBUF-1 to 0.
- Outputs:
  - pattern_out and field_byte_out register, each clk, the values indexed by the current bufp/fieldp registers.
  - A pointer change therefore appears on the outputs 1 clk after the pointer register updates.
  - A commit to buffer[bufp] appears on pattern_out 1 clk after the COMMIT cycle.
  - A commit and a pointer change in the same clk are independent; the next clk shows the new pointer's data, including the new commit if it targets that buffer.
- Other rules:
  - ssel rising while in COMMIT is ignored. The host must hold ssel low for >= 3 clk between frames.
  - The serial load path never stalls the pointer or output path.

Test Plan:
- Reset, then shift a full frame: ssel=1, saddr=2, N=256 bits of pattern 0xA5 in every field, ssel=0. Required: load_done=1 for exactly one clk and load_err=0. After incbufp twice, pattern_out = 0xA5 in all 32 fields and field_byte_out = 0xA5.
- Short frame of 255 bits to buffer 2: load_err pulses once and load_done stays 0. Buffer 2 still reads 0xA5 in every field.
- Long frame of 257 bits: load_err pulses once and the buffer is unchanged.
- Readback: buffer 1 holds field31 = 0x80 and all other fields 0. Start a frame to buffer 1. Required: the first sout bit after SHIFT entry is 1, followed by 255 zeros.
- autofield=1 from bufp=7, fieldp=0: fieldp steps 0..31 over 32 clks. On the clk where fieldp wraps 31->0, bufp wraps 7->0. With incbufp=1 on that same clk, bufp still lands at 0 (advanced by 1, not 2).
- Reset asserted mid-frame after 100 bits: state returns to IDLE, no pulses, all buffers 0, sout=0. A subsequent full frame commits normally.
